// File: rtl/key_event_pkg.sv
// Shared types and 50 MHz default timings for the key event decoder.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } key_state_e;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned DCLICK_CYCLES_DEF = 12_500_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registers a synchronous key level and flags its rising and falling edges.
module key_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= RST_VAL;
    else        level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;
  assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into click, double-click, long-press and auto-repeat pulses.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise repeat_p is tied to 0.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned DCLICK_CYCLES = DCLICK_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic repeat_p,
  output logic busy
);

  localparam int unsigned CW = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES));

  logic          rise, fall;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          click_q, click_d, dclick_q, dclick_d, long_q, long_d, busy_q, busy_d;
`ifdef KEY_REPEAT_EN
  logic          repeat_q, repeat_d;
`endif

  // Reset value 1: a key already held when reset lifts must be released first.
  key_edge_det #(.RST_VAL(1'b1)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .level_i(key_level),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LONG_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DCLICK_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d  = IDLE;
          cnt_d    = '0;
          dclick_d = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (cnt_q == CW'(REPEAT_CYCLES - 1)) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_q <= 1'b0;
    else        repeat_q <= repeat_d;
  end
  assign repeat_p = repeat_q;
`else
  assign repeat_p = 1'b0;
`endif

  assign click_p  = click_q;
  assign dclick_p = dclick_q;
  assign long_p   = long_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG=20, DCLICK=8, REPEAT=5.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic key_level;
  logic click_p, dclick_p, long_p, repeat_p, busy;

  int tests = 0;
  int fails = 0;

  logic kp [0:79];
  logic rp [0:79];
  logic busy_log [0:79];
  int click_cnt, click_at, dclick_cnt, dclick_at, long_cnt, long_at, rep_cnt, multi_cnt;
  int rep_at [$];

  key_event_decoder #(
    .LONG_CYCLES  (20),
    .DCLICK_CYCLES(8),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_level(key_level),
    .click_p  (click_p),
    .dclick_p (dclick_p),
    .long_p   (long_p),
    .repeat_p (repeat_p),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_pat();
    for (int i = 0; i < 80; i++) begin
      kp[i] = 1'b0;
      rp[i] = 1'b1;
      busy_log[i] = 1'b0;
    end
  endtask

  task automatic set_key(input int from, input int to);
    for (int i = from; i <= to; i++) kp[i] = 1'b1;
  endtask

  // Cycle c: inputs driven just after the edge, outputs sampled 1 ns later.
  task automatic run(input int n);
    int ones;
    click_cnt = 0; click_at = -1; dclick_cnt = 0; dclick_at = -1;
    long_cnt = 0; long_at = -1; rep_cnt = 0; multi_cnt = 0;
    rep_at.delete();
    for (int c = 0; c < n; c++) begin
      key_level = kp[c];
      rst_n     = rp[c];
      #1;
      busy_log[c] = busy;
      ones = int'(click_p) + int'(dclick_p) + int'(long_p) + int'(repeat_p);
      if (ones > 1) multi_cnt++;
      if (click_p)  begin click_cnt++;  click_at = c;  end
      if (dclick_p) begin dclick_cnt++; dclick_at = c; end
      if (long_p)   begin long_cnt++;   long_at = c;   end
      if (repeat_p) begin rep_cnt++;    rep_at.push_back(c); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({click_p, dclick_p, long_p, repeat_p, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {click_p, dclick_p, long_p, repeat_p, busy});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_click();
    clear_pat();
    set_key(1, 5);
    run(40);
    tests++; if (click_cnt !== 1)  begin fails++; $display("FAIL click_count: got %0d expected 1", click_cnt); end
    tests++; if (click_at !== 15)  begin fails++; $display("FAIL click_cycle: got %0d expected 15", click_at); end
    tests++; if (dclick_cnt + long_cnt + rep_cnt !== 0) begin
      fails++; $display("FAIL click_others: got %0d expected 0", dclick_cnt + long_cnt + rep_cnt); end
    tests++; if ({busy_log[1], busy_log[2], busy_log[14], busy_log[15]} !== 4'b0110) begin
      fails++; $display("FAIL click_busy: got %b expected 0110",
                        {busy_log[1], busy_log[2], busy_log[14], busy_log[15]}); end
  endtask

  task automatic test_dclick();
    clear_pat();
    set_key(1, 3);
    set_key(7, 9);
    run(30);
    tests++; if (dclick_cnt !== 1) begin fails++; $display("FAIL dclick_count: got %0d expected 1", dclick_cnt); end
    tests++; if (dclick_at !== 11) begin fails++; $display("FAIL dclick_cycle: got %0d expected 11", dclick_at); end
    tests++; if (click_cnt !== 0)  begin fails++; $display("FAIL dclick_noclick: got %0d expected 0", click_cnt); end
    tests++; if ({busy_log[10], busy_log[11]} !== 2'b10) begin
      fails++; $display("FAIL dclick_busy: got %b expected 10", {busy_log[10], busy_log[11]}); end
  endtask

  task automatic test_long();
`ifdef KEY_REPEAT_EN
    clear_pat();
    set_key(1, 38);
    run(50);
    tests++; if (long_cnt !== 1) begin fails++; $display("FAIL long_count: got %0d expected 1", long_cnt); end
    tests++; if (long_at !== 22) begin fails++; $display("FAIL long_cycle: got %0d expected 22", long_at); end
    tests++; if (rep_cnt !== 3)  begin fails++; $display("FAIL repeat_count: got %0d expected 3", rep_cnt); end
    if (rep_cnt == 3) begin
      tests++;
      if (rep_at[0] !== 27 || rep_at[1] !== 32 || rep_at[2] !== 37) begin
        fails++;
        $display("FAIL repeat_cycles: got %0d,%0d,%0d expected 27,32,37", rep_at[0], rep_at[1], rep_at[2]);
      end
    end
    tests++; if (click_cnt !== 0) begin fails++; $display("FAIL repeat_noclick: got %0d expected 0", click_cnt); end
`else
    clear_pat();
    set_key(1, 40);
    run(60);
    tests++; if (long_cnt !== 1) begin fails++; $display("FAIL long_count: got %0d expected 1", long_cnt); end
    tests++; if (long_at !== 22) begin fails++; $display("FAIL long_cycle: got %0d expected 22", long_at); end
    tests++; if (rep_cnt !== 0)  begin fails++; $display("FAIL long_norepeat: got %0d expected 0", rep_cnt); end
    tests++; if (click_cnt + dclick_cnt !== 0) begin
      fails++; $display("FAIL long_noclick: got %0d expected 0", click_cnt + dclick_cnt); end
    tests++; if ({busy_log[41], busy_log[42]} !== 2'b10) begin
      fails++; $display("FAIL long_busy: got %b expected 10", {busy_log[41], busy_log[42]}); end
`endif
  endtask

  task automatic test_fall_beats_long();
    clear_pat();
    set_key(1, 20);
    run(45);
    tests++; if (long_cnt !== 0)  begin fails++; $display("FAIL edge_nolong: got %0d expected 0", long_cnt); end
    tests++; if (click_cnt !== 1) begin fails++; $display("FAIL edge_click_count: got %0d expected 1", click_cnt); end
    tests++; if (click_at !== 30) begin fails++; $display("FAIL edge_click_cycle: got %0d expected 30", click_at); end
  endtask

  task automatic test_reset_mid();
    logic any_busy;
    clear_pat();
    set_key(1, 20);
    set_key(26, 30);
    rp[11] = 1'b0;
    rp[12] = 1'b0;
    run(55);
    any_busy = 1'b0;
    for (int i = 11; i <= 25; i++) any_busy = any_busy | busy_log[i];
    tests++; if (any_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", any_busy); end
    tests++; if (long_cnt + dclick_cnt + rep_cnt !== 0) begin
      fails++; $display("FAIL rstmid_others: got %0d expected 0", long_cnt + dclick_cnt + rep_cnt); end
    tests++; if (click_cnt !== 1) begin fails++; $display("FAIL rstmid_click_count: got %0d expected 1", click_cnt); end
    tests++; if (click_at !== 40) begin fails++; $display("FAIL rstmid_click_cycle: got %0d expected 40", click_at); end
  endtask

  task automatic test_one_hot();
    // multi_cnt accumulates only within a run, so re-run a mixed pattern.
    clear_pat();
    set_key(1, 3);
    set_key(5, 7);
    set_key(18, 45);
    run(70);
    tests++; if (multi_cnt !== 0) begin fails++; $display("FAIL one_pulse: got %0d expected 0", multi_cnt); end
    tests++; if (dclick_at !== 9) begin fails++; $display("FAIL mixed_dclick: got %0d expected 9", dclick_at); end
    tests++; if (long_at !== 39)  begin fails++; $display("FAIL mixed_long: got %0d expected 39", long_at); end
  endtask

  initial begin
    rst_n = 1'b0;
    key_level = 1'b0;
    test_reset();
    test_click();
    test_dclick();
    test_long();
    test_fall_beats_long();
    test_reset_mid();
    test_one_hot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
